// File: rtl/full_st1_bias_ctrl_pkg.sv
// Shared types and constants for the stage-1 bias memory controller.
package full_st1_bias_ctrl_pkg;

  localparam int unsigned BIAS_DATA_W = 32;
  localparam int unsigned BIAS_ADDR_W = 3;
  localparam int unsigned BIAS_DEPTH  = 8;

  typedef enum logic [1:0] {
    EMPTY,
    LOADING,
    LOADED
  } bias_state_t;

  typedef struct packed {
    logic [BIAS_ADDR_W-1:0] addr;
    logic                   wr_en;
    logic                   rd_en;
  } bias_mem_ctrl_t;

endpackage

// File: rtl/full_st1_bias_ctrl_rd_pipe.sv
// One-cycle read response stage: aligns rd_valid/rd_last with the memory's
// registered read data and flushes any in-flight response on reset.
module full_st1_bias_rd_pipe #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_accept,
  input  logic              last_in,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last
);

  logic valid_q;
  logic last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= rd_accept;
      last_q  <= rd_accept & last_in;
    end
  end

  // The memory already registers its output, so data is gated rather than re-registered.
  assign rd_valid = valid_q;
  assign rd_last  = last_q;
  assign rd_data  = valid_q ? mem_rd_data : '0;

endmodule

// File: rtl/full_st1_bias_ctrl.sv
// Stage-1 bias memory sequencer/arbiter: loader writes, datapath reads, load-before-use.
// Optional: FULL_ST1_BIAS_AUTO_INC_EN replaces rd_addr with an internal wrapping read pointer.
module full_st1_bias_ctrl
  import full_st1_bias_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = BIAS_DATA_W,
  parameter int unsigned ADDR_W = BIAS_ADDR_W,
  parameter int unsigned DEPTH  = BIAS_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_load,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output bias_mem_ctrl_t    mem_ctrl,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              loaded
);

  bias_state_t       state;
  logic [ADDR_W:0]   count;
  logic              ld_accept;
  logic              rd_accept;
  logic [ADDR_W-1:0] rd_sel_addr;
  logic              rd_last_next;

  assign ld_ready  = (state == LOADING);
  assign rd_ready  = (state == LOADED) && !start_load;
  assign ld_accept = ld_valid && ld_ready;
  assign rd_accept = rd_req && rd_ready;

`ifdef FULL_ST1_BIAS_AUTO_INC_EN
  logic [ADDR_W-1:0] rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (start_load) begin
      rd_ptr <= '0;
    end else if (rd_accept) begin
      rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_sel_addr  = rd_ptr;
  assign rd_last_next = (rd_ptr == ADDR_W'(DEPTH - 1));
`else
  assign rd_sel_addr  = rd_addr;
  assign rd_last_next = 1'b0;
`endif

  // Writes only happen in LOADING and reads only in LOADED, so the port never conflicts.
  always_comb begin
    mem_ctrl    = '0;
    mem_wr_data = '0;
    if (ld_accept) begin
      mem_ctrl.wr_en = 1'b1;
      mem_ctrl.addr  = count[ADDR_W-1:0];
      mem_wr_data    = ld_data;
    end else if (rd_accept) begin
      mem_ctrl.rd_en = 1'b1;
      mem_ctrl.addr  = rd_sel_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      count  <= '0;
      loaded <= 1'b0;
    end else if (start_load) begin
      state  <= LOADING;
      count  <= '0;
      loaded <= 1'b0;
    end else begin
      case (state)
        LOADING: begin
          if (ld_accept) begin
            count <= count + 1'b1;
            if (count == (ADDR_W + 1)'(DEPTH - 1)) begin
              state  <= LOADED;
              loaded <= 1'b1;
            end
          end
        end
        LOADED:  state <= LOADED;
        default: state <= EMPTY;
      endcase
    end
  end

  full_st1_bias_rd_pipe #(
    .DATA_W(DATA_W)
  ) u_rd_pipe (
    .clk        (clk),
    .reset      (reset),
    .rd_accept  (rd_accept),
    .last_in    (rd_last_next),
    .mem_rd_data(mem_rd_data),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_last    (rd_last)
  );

endmodule
